// File: rtl/hub75_capture.sv
// HUB75 panel snoop: rebuilds each latched row and streams it out as valid/ready pixel beats.
// Also measures lit time per latch period and raises sticky protocol error flags.
module hub75_capture #(
    parameter int unsigned COLS     = 64,
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned ROW_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_clk,
    input  logic                d_lat,
    input  logic                d_oe,
    input  logic [ROW_BITS-1:0] d_addr,
    input  logic [2:0]          display_rgb1,
    input  logic [2:0]          display_rgb2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROW_BITS-1:0] out_row,
    output logic [COL_BITS-1:0] out_col,
    output logic [2:0]          out_rgb1,
    output logic [2:0]          out_rgb2,
    output logic [15:0]         oe_cycles,
    output logic                oe_valid,
    output logic                err_short,
    output logic                err_long,
    output logic                err_drop,
    input  logic                err_clr
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS + 1)'(COLS);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);

    logic                s1_clk, s1_lat, s1_oe;
    logic [ROW_BITS-1:0] s1_addr;
    logic [2:0]          s1_rgb1, s1_rgb2;
    logic                s2_clk, s2_lat;

    logic [5:0]          shift_buf [COLS];
    logic [5:0]          row_buf   [COLS];
    logic [COL_BITS:0]   col_cnt;
    logic [COL_BITS-1:0] idx;
    logic [0:0]          state;
    logic [15:0]         lit_cnt;

    logic shift_edge, latch_edge, xfer, last_beat, accept, drop;

    assign shift_edge = s1_clk & ~s2_clk;
    assign latch_edge = s1_lat & ~s2_lat;
    assign xfer       = (state == ST_STREAM) & out_ready;
    assign last_beat  = (idx == LAST_COL);
    // A latch landing on the final transfer is accepted as if the FSM were already idle.
    assign accept     = latch_edge & ((state == ST_IDLE) | (xfer & last_beat));
    assign drop       = latch_edge & ~accept;

    assign out_valid  = (state == ST_STREAM);
    assign out_col    = idx;
    assign {out_rgb2, out_rgb1} = row_buf[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_clk  <= 1'b0;
            s1_lat  <= 1'b0;
            s1_oe   <= 1'b0;
            s1_addr <= '0;
            s1_rgb1 <= '0;
            s1_rgb2 <= '0;
            s2_clk  <= 1'b0;
            s2_lat  <= 1'b0;
        end else begin
            s1_clk  <= d_clk;
            s1_lat  <= d_lat;
            s1_oe   <= d_oe;
            s1_addr <= d_addr;
            s1_rgb1 <= display_rgb1;
            s1_rgb2 <= display_rgb2;
            s2_clk  <= s1_clk;
            s2_lat  <= s1_lat;
        end
    end

    // A coincident shift starts the next row at column 0 while the latch copies the old buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) shift_buf[i] <= '0;
            col_cnt <= '0;
        end else if (latch_edge) begin
            if (shift_edge) begin
                shift_buf[0] <= {s1_rgb2, s1_rgb1};
                col_cnt      <= (COL_BITS + 1)'(1);
            end else begin
                col_cnt <= '0;
            end
        end else if (shift_edge && col_cnt < COLS_W) begin
            shift_buf[col_cnt[COL_BITS-1:0]] <= {s1_rgb2, s1_rgb1};
            col_cnt <= col_cnt + (COL_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) row_buf[i] <= '0;
            state   <= ST_IDLE;
            idx     <= '0;
            out_row <= '0;
        end else if (accept) begin
            row_buf <= shift_buf;
            out_row <= s1_addr;
            state   <= ST_STREAM;
            idx     <= '0;
        end else if (xfer) begin
            if (last_beat) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + COL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            err_short <= (accept & (col_cnt < COLS_W)) | (err_short & ~err_clr);
            err_long  <= (shift_edge & ~latch_edge & (col_cnt >= COLS_W)) | (err_long & ~err_clr);
            err_drop  <= drop | (err_drop & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lit_cnt   <= '0;
            oe_cycles <= '0;
            oe_valid  <= 1'b0;
        end else if (latch_edge) begin
            oe_cycles <= lit_cnt;
            oe_valid  <= 1'b1;
            lit_cnt   <= '0;
        end else begin
            oe_valid <= 1'b0;
            if (!s1_oe && lit_cnt != '1) lit_cnt <= lit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
// Randomized bench for hub75_capture: a pixel-list row model feeds a beat scoreboard,
// and error flags and the lit-time meter are checked against the same model.
module tb_hub75_capture;

    logic       clk, rst;
    logic       d_clk, d_lat, d_oe;
    logic [3:0] d_addr;
    logic [2:0] display_rgb1, display_rgb2;
    logic       out_valid, out_ready;
    logic [3:0] out_row;
    logic [5:0] out_col;
    logic [2:0] out_rgb1, out_rgb2;
    logic [15:0] oe_cycles;
    logic       oe_valid, err_short, err_long, err_drop, err_clr;

    hub75_capture #(.COLS(64), .COL_BITS(6), .ROW_BITS(4)) dut (
        .clk(clk), .rst(rst), .d_clk(d_clk), .d_lat(d_lat), .d_oe(d_oe), .d_addr(d_addr),
        .display_rgb1(display_rgb1), .display_rgb2(display_rgb2),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_rgb1(out_rgb1), .out_rgb2(out_rgb2), .oe_cycles(oe_cycles), .oe_valid(oe_valid),
        .err_short(err_short), .err_long(err_long), .err_drop(err_drop), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: pixel buffer as the panel would hold it, pixel count since last latch.
    logic [5:0]  m_sb [64];
    int          m_cnt;
    bit          e_short, e_long, e_drop;
    logic [15:0] beat_q [$];
    int          beat_cnt;
    int          ready_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int c = 0; c < 64; c++) m_sb[c] = '0;
        m_cnt = 0;
        e_short = 0; e_long = 0; e_drop = 0;
        beat_q.delete();
    endtask

    task automatic model_shift(input logic [5:0] px);
        if (m_cnt < 64) begin
            m_sb[m_cnt] = px;
            m_cnt++;
        end else begin
            e_long = 1;
        end
    endtask

    task automatic model_latch(input logic [3:0] addr, input bit busy);
        if (!busy) begin
            for (int c = 0; c < 64; c++)
                beat_q.push_back({addr, 6'(c), m_sb[c][2:0], m_sb[c][5:3]});
            if (m_cnt < 64) e_short = 1;
        end else begin
            e_drop = 1;
        end
        m_cnt = 0;
    endtask

    task automatic shift_px(input logic [5:0] px);
        display_rgb1 = px[2:0];
        display_rgb2 = px[5:3];
        d_clk = 1'b1;
        model_shift(px);
        repeat ($urandom_range(1, 2)) tick;
        d_clk = 1'b0;
        repeat ($urandom_range(1, 2)) tick;
    endtask

    task automatic do_latch(input logic [3:0] addr, input bit busy, input bit chk_lat,
                            input bit with_px, input logic [5:0] px);
        d_addr = addr;
        d_lat  = 1'b1;
        model_latch(addr, busy);
        if (with_px) begin
            display_rgb1 = px[2:0];
            display_rgb2 = px[5:3];
            d_clk = 1'b1;
            model_shift(px);
        end
        tick;
        if (chk_lat) check("latency_cycle1", out_valid, 0);
        d_lat = 1'b0;
        d_clk = 1'b0;
        tick;
        if (chk_lat) check("latency_cycle2", out_valid, 1);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((beat_q.size() != 0 || out_valid) && n < 2000) begin
            tick;
            n++;
        end
        check("stream_done", (beat_q.size() == 0 && !out_valid), 1);
    endtask

    task automatic check_errs(input string tag);
        check(tag, {err_short, err_long, err_drop}, {e_short, e_long, e_drop});
    endtask

    task automatic clear_errs;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        e_short = 0; e_long = 0; e_drop = 0;
        check_errs("err_clr");
    endtask

    task automatic run_row(input int n, input logic [3:0] addr, input int mode, input bit pat);
        logic [2:0] c3;
        ready_mode = mode;
        for (int i = 0; i < n; i++) begin
            c3 = 3'(i);
            if (pat) shift_px({~c3, c3});
            else     shift_px(6'($urandom));
        end
        beat_cnt = 0;
        do_latch(addr, 0, pat, 0, 6'd0);
        wait_idle;
        check("beat_count", beat_cnt, 64);
        check_errs("row_errs");
    endtask

    task automatic oe_period(input int n);
        int exp_n;
        exp_n = (n > 65535) ? 65535 : n;
        ready_mode = 0;
        do_latch(4'd1, 0, 0, 0, 6'd0);
        d_oe = 1'b0;
        repeat (n) tick;
        d_oe = 1'b1;
        wait_idle;
        d_addr = 4'd2;
        d_lat  = 1'b1;
        model_latch(4'd2, 0);
        tick;
        check("oe_valid_before", oe_valid, 0);
        d_lat = 1'b0;
        tick;
        check("oe_valid_pulse", oe_valid, 1);
        check("oe_cycles", oe_cycles, exp_n);
        tick;
        check("oe_valid_after", oe_valid, 0);
        wait_idle;
        clear_errs;
    endtask

    // Ready driver: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beat scoreboard plus hold-while-stalled check.
    bit          prev_stall = 0;
    logic [15:0] held;
    always @(negedge clk) begin
        logic [15:0] cur, e;
        cur = {out_row, out_col, out_rgb1, out_rgb2};
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", cur, held);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    e = beat_q.pop_front();
                    check("beat", cur, e);
                    beat_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            held = cur;
        end
    end

    initial begin
        logic [5:0] px;
        int n;
        rst = 1'b1; d_clk = 0; d_lat = 0; d_oe = 1; d_addr = '0;
        display_rgb1 = '0; display_rgb2 = '0; err_clr = 0; ready_mode = 0; beat_cnt = 0;
        model_reset;
        repeat (3) tick;
        check("rst_stream", {out_valid, out_row, out_col, out_rgb1, out_rgb2}, 0);
        check("rst_oe", {oe_valid, oe_cycles}, 0);
        check("rst_errs", {err_short, err_long, err_drop}, 0);
        rst = 1'b0;
        tick;

        run_row(64, 4'd5, 0, 1);

        run_row(40, 4'($urandom), 2, 0);
        clear_errs;

        run_row(70, 4'($urandom), 2, 0);
        clear_errs;

        ready_mode = 1;
        for (int i = 0; i < 64; i++) shift_px(6'($urandom));
        beat_cnt = 0;
        do_latch(4'd9, 0, 0, 0, 6'd0);
        repeat (8) tick;
        do_latch(4'd3, 1, 0, 0, 6'd0);
        wait_idle;
        check("drop_beats", beat_cnt, 64);
        check_errs("drop_errs");
        clear_errs;

        ready_mode = 2;
        for (int i = 0; i < 63; i++) shift_px(6'($urandom));
        beat_cnt = 0;
        px = 6'($urandom);
        do_latch(4'd7, 0, 0, 1, px);
        wait_idle;
        check("coincident_beats", beat_cnt, 64);
        check_errs("coincident_errs");
        clear_errs;
        run_row(63, 4'd8, 2, 0);

        for (int r = 0; r < 4; r++) begin
            run_row($urandom_range(60, 68), 4'($urandom), 2, 0);
            clear_errs;
        end

        oe_period(300);
        oe_period($urandom_range(1, 500));
        oe_period(70000);

        ready_mode = 0;
        for (int i = 0; i < 50; i++) shift_px(6'($urandom));
        beat_cnt = 0;
        do_latch(4'd11, 0, 0, 0, 6'd0);
        n = 0;
        while (beat_cnt < 20 && n < 300) begin
            tick;
            n++;
        end
        check("beat20_reached", beat_cnt >= 20, 1);
        rst = 1'b1;
        model_reset;
        tick;
        check("midrst_valid", out_valid, 0);
        check("midrst_errs", {err_short, err_long, err_drop}, 0);
        rst = 1'b0;
        tick;
        run_row(64, 4'd12, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
